conbus_rr: RTL and testbench
============================

Name: conbus_rr

Overview:
- Parametrised successor to the fixed 6-master/7-slave Wishbone conbus.
- Connects NM masters to NS slaves over one shared bus.
- Arbitration is registered and round-robin, replacing fixed priority.
- Masters receive a Wishbone err termination for unmapped addresses and for slaves that fail to ack within TIMEOUT cycles.
- Sits between the CPU/DMA masters and the peripheral, memory and CSR slaves of the SoC.

Parameters:
- NM, 6, number of masters (2..16).
- NS, 7, number of slaves (1..16).
- S_ADDR_W, 4, number of address MSBs decoded.
- S_ADDR, {4'h6,4'h5,4'h4,4'h3,4'h2,4'h1,4'h0}, packed NS×S_ADDR_W table; slice i is the base of slave i.
- TO_W, 8, width of the timeout counter.
- TIMEOUT, 255, cycles without ack before err is asserted; 0 disables the timeout.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- m_dat_i  in  NM*32  master write data; slice i belongs to master i (same slicing for all m_* vectors).
- m_adr_i  in  NM*32  master address.
- m_cti_i  in  NM*3  master cycle type.
- m_sel_i  in  NM*4  master byte selects.
- m_we_i  in  NM  master write enable.
- m_cyc_i  in  NM  master cycle.
- m_stb_i  in  NM  master strobe.
- m_dat_o  out  32  read data, shared by all masters.
- m_ack_o  out  NM  per-master ack.
- m_err_o  out  NM  per-master err.
- s_dat_i  in  NS*32  slave read data.
- s_ack_i  in  NS  slave ack.
- s_dat_o  out  32  shared write data.
- s_adr_o  out  32  shared address.
- s_cti_o  out  3  shared cycle type.
- s_sel_o  out  4  shared byte selects.
- s_we_o  out  1  shared write enable.
- s_cyc_o  out  NS  per-slave cycle.
- s_stb_o  out  NS  per-slave strobe.
- gnt_o  out  NM  current one-hot grant (debug/perf).

Behaviour:
- Reset values: gnt=0, last=NM-1, to_cnt=0, err_q=0. Therefore all m_ack_o, m_err_o, s_cyc_o and s_stb_o are 0, and the shared buses are 0 (AND-OR mux with no grant).
- Arbiter states:
  - IDLE (gnt=0).
  - OWN (gnt one-hot, owner o).
- Arbiter transitions:
  - IDLE with any m_cyc_i: at the next edge, grant the first requester scanning last+1, last+2, … mod NM. Then last<=winner, go to OWN. Latency: cyc high at edge k gives gnt at edge k+1.
  - OWN: gnt is held while m_cyc_i[o]=1, regardless of other requests; there is no preemption.
  - OWN with m_cyc_i[o]=0 sampled: re-arbitrate at that same edge, using the same rule over current requests. Go to OWN(new) with no dead cycle, or to IDLE if there are no requests.
- Mux: the shared bus carries the granted master's adr/cti/sel/dat/we/cyc/stb.
- Decode: slave i is selected when s_adr_o[31:32-S_ADDR_W]==S_ADDR slice i. Lowest index wins on overlap; nomatch when no slice matches.
- Slave outputs:
  - s_cyc_o[i] = cyc & sel_i.
  - s_stb_o[i] = cyc & stb & sel_i & !err_q.
  - m_dat_o = read data of the selected slave, 0 if nomatch.
- Ack: m_ack_o[o] = gnt[o] & |(s_ack_i & sel). This path is combinational, zero added latency. Acks from unselected slaves are ignored.
- Active: active = cyc & stb & !ack & !err_q.
- Unmapped address: err_q<=1 at the edge where active & nomatch. This gives one err cycle after each unmapped strobe. If the master holds stb, err repeats every 2nd cycle.
- Timeout:
  - to_cnt increments while active & !nomatch; it clears on ack, !stb, err_q or a grant change.
  - When to_cnt==TIMEOUT-1 and active: err_q<=1 and to_cnt<=0. This yields err on cycle TIMEOUT+1 after strobe.
  - TIMEOUT=0 disables the timeout.
  - to_cnt saturates, never wraps.
- err_q: clears the cycle after it is set. m_err_o[o] = gnt[o] & err_q. While err_q=1, slave stb is masked.
- Simultaneous events:
  - Slave ack in the same cycle as the timeout terminal count: ack wins, no err.
  - Owner drops cyc while err_q=1: err_q clears at the edge anyway; the new owner never sees it.
- Reset asserted mid-transfer: immediate asynchronous return to reset values. Slaves see stb fall without ack and must tolerate it.

Test Plan:
1. NM=6 defaults; masters 0, 2 and 5 raise cyc together at t0 after reset → gnt_o=6'b000001 at t0+1; after m0 drops cyc, 6'b000100 with no gap; then 6'b100000.
2. m3 reads 0x3000_0010 and s3 acks 2 cycles after stb → only s_stb_o[3] high; m_ack_o[3] coincides with s_ack_i[3]; m_dat_o = s3 data; m_err_o=0.
3. S_ADDR_W=4, NS=7; m1 strobes 0xF000_0000 → m_err_o[1] for exactly 1 cycle, one cycle after stb; no s_stb_o asserted.
4. TIMEOUT=8; s2 never acks → m_err_o pulses on cycle 9 after stb; s_stb_o[2] low during the err cycle.
5. s4 ack coincides with timeout terminal count → ack delivered, m_err_o stays 0, to_cnt returns to 0.
6. sys_rst_n low mid-burst while m0 owns the bus → gnt_o, s_cyc_o and s_stb_o go to 0 asynchronously; after release, m1 requesting alone is granted 1 cycle later.

Source files
------------

// File: rtl/conbus_rr_if.sv
// Shared-bus signal bundle for conbus_rr: NM Wishbone masters on one side, NS slaves on the other.
// The slave modport is the interconnect's view; the master modport is the view of the
// surrounding masters and slaves that drive and observe the interconnect.
interface conbus_rr_if #(
  parameter int unsigned NM = 6,
  parameter int unsigned NS = 7
);
  logic [NM*32-1:0] m_dat_i;
  logic [NM*32-1:0] m_adr_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM-1:0]    m_we_i;
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [NS*32-1:0] s_dat_i;
  logic [NS-1:0]    s_ack_i;
  logic [31:0]      s_dat_o;
  logic [31:0]      s_adr_o;
  logic [2:0]       s_cti_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o;
  logic [NS-1:0]    s_cyc_o;
  logic [NS-1:0]    s_stb_o;

  modport slave (
    input  m_dat_i, m_adr_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, s_dat_o, s_adr_o, s_cti_o, s_sel_o, s_we_o, s_cyc_o,
           s_stb_o
  );

  modport master (
    output m_dat_i, m_adr_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, s_dat_o, s_adr_o, s_cti_o, s_sel_o, s_we_o, s_cyc_o,
           s_stb_o
  );
endinterface

// File: rtl/conbus_rr.sv
// Wishbone shared-bus interconnect: NM masters, NS slaves, registered round-robin arbitration,
// address decode on the top S_ADDR_W bits, and err termination for unmapped addresses and
// slaves that do not ack within TIMEOUT cycles.
module conbus_rr #(
  parameter int unsigned             NM       = 6,
  parameter int unsigned             NS       = 7,
  parameter int unsigned             S_ADDR_W = 4,
  parameter logic [NS*S_ADDR_W-1:0]  S_ADDR   = {4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0},
  parameter int unsigned             TO_W     = 8,
  parameter int unsigned             TIMEOUT  = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  conbus_rr_if.slave        bus,
  output logic [NM-1:0]     gnt_o
);

  localparam int unsigned     LW     = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [TO_W-1:0] ToTerm = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] ToMax  = '1;

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e          state_q, state_d;
  logic [NM-1:0]   gnt_q, gnt_d;
  logic [LW-1:0]   last_q, last_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;

  logic            own_cyc;
  logic            found;
  logic [LW-1:0]   winner;
  logic [LW-1:0]   cand;
  int unsigned     idx;

  logic [31:0]     adr, wdat, rdat;
  logic [2:0]      cti;
  logic [3:0]      bsel;
  logic            we, cyc, stb;
  logic [NS-1:0]   sel;
  logic            nomatch;
  logic            ack, active, gnt_chg;

  // Arbiter next state: first requester after the last winner, re-arbitrating only when idle
  // or when the current owner has dropped cyc.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    found   = 1'b0;
    winner  = '0;
    cand    = '0;
    idx     = 0;
    own_cyc = |(bus.m_cyc_i & gnt_q);
    for (int unsigned k = 1; k <= NM; k++) begin
      idx  = (32'(last_q) + k) % NM;
      cand = LW'(idx);
      if (!found && bus.m_cyc_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d   = NM'(1) << winner;
          last_d  = winner;
          state_d = StOwn;
        end
      end
      StOwn: begin
        if (!own_cyc) begin
          if (found) begin
            gnt_d  = NM'(1) << winner;
            last_d = winner;
          end else begin
            gnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // AND-OR mux of the granted master onto the shared bus; all zero with no grant.
  always_comb begin
    adr  = '0;
    wdat = '0;
    cti  = '0;
    bsel = '0;
    we   = 1'b0;
    cyc  = 1'b0;
    stb  = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      adr  = adr  | ({32{gnt_q[i]}} & bus.m_adr_i[i*32 +: 32]);
      wdat = wdat | ({32{gnt_q[i]}} & bus.m_dat_i[i*32 +: 32]);
      cti  = cti  | ({3{gnt_q[i]}}  & bus.m_cti_i[i*3 +: 3]);
      bsel = bsel | ({4{gnt_q[i]}}  & bus.m_sel_i[i*4 +: 4]);
      we   = we   | (gnt_q[i] & bus.m_we_i[i]);
      cyc  = cyc  | (gnt_q[i] & bus.m_cyc_i[i]);
      stb  = stb  | (gnt_q[i] & bus.m_stb_i[i]);
    end
  end

  // Address decode (lowest matching slave wins) and read-data select.
  always_comb begin
    sel     = '0;
    nomatch = 1'b1;
    rdat    = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (nomatch && (adr[31 -: S_ADDR_W] == S_ADDR[i*S_ADDR_W +: S_ADDR_W])) begin
        sel[i]  = 1'b1;
        nomatch = 1'b0;
      end
    end
    for (int unsigned i = 0; i < NS; i++) begin
      rdat = rdat | ({32{sel[i]}} & bus.s_dat_i[i*32 +: 32]);
    end
  end

  // Error and timeout next state; a same-cycle ack keeps the transfer out of "active" so it
  // always beats the terminal count.
  always_comb begin
    ack      = |(bus.s_ack_i & sel);
    active   = cyc & stb & ~ack & ~err_q;
    gnt_chg  = (gnt_d != gnt_q);
    err_d    = 1'b0;
    to_cnt_d = to_cnt_q;
    if (active && nomatch) begin
      err_d = 1'b1;
    end else if ((TIMEOUT != 0) && active && (to_cnt_q == ToTerm)) begin
      err_d = 1'b1;
    end
    if (ack || !stb || !cyc || err_q || gnt_chg || err_d) begin
      to_cnt_d = '0;
    end else if (active && (to_cnt_q != ToMax)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // State registers; reset leaves last at NM-1 so master 0 is scanned first.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      last_q   <= LW'(NM - 1);
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  // Output drive: slave strobes are masked during the err cycle.
  always_comb begin
    bus.s_adr_o = adr;
    bus.s_dat_o = wdat;
    bus.s_cti_o = cti;
    bus.s_sel_o = bsel;
    bus.s_we_o  = we;
    bus.s_cyc_o = sel & {NS{cyc}};
    bus.s_stb_o = sel & {NS{cyc & stb & ~err_q}};
    bus.m_dat_o = rdat;
    bus.m_ack_o = gnt_q & {NM{ack}};
    bus.m_err_o = gnt_q & {NM{err_q}};
    gnt_o       = gnt_q;
  end

endmodule

// File: tb/tb_conbus_rr.sv
// Directed bench for conbus_rr: stimulus pushes expected ack/err responses into a scoreboard
// queue, a forked monitor pops and checks them whenever a master ack or err appears.
module tb_conbus_rr;
  localparam int NM = 6;
  localparam int NS = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NM-1:0] gnt;

  always #5 clk = ~clk;

  conbus_rr_if #(.NM(NM), .NS(NS)) bus ();

  conbus_rr #(
    .NM(NM), .NS(NS), .S_ADDR_W(4),
    .S_ADDR({4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0}),
    .TO_W(8), .TIMEOUT(8)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .bus(bus),
    .gnt_o(gnt)
  );

  typedef struct {
    bit          is_err;
    int          m;
    bit          chk_dat;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input logic c, input logic s, input logic [31:0] a,
                       input logic w);
    bus.m_cyc_i[i]          = c;
    bus.m_stb_i[i]          = s;
    bus.m_adr_i[i*32 +: 32] = a;
    bus.m_we_i[i]           = w;
    bus.m_sel_i[i*4 +: 4]   = 4'hf;
    bus.m_cti_i[i*3 +: 3]   = 3'b000;
    bus.m_dat_i[i*32 +: 32] = 32'h1000_0000 + i;
  endtask

  task automatic push(input bit e, input int m, input bit cd, input logic [31:0] d, input int c);
    exp_t x;
    x.is_err = e;
    x.m = m;
    x.chk_dat = cd;
    x.dat = d;
    x.cyc = c;
    q.push_back(x);
  endtask

  task automatic monitor();
    exp_t e;
    logic [NM-1:0] ea, ee;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (q.size() > 0 && cyc_cnt > q[0].cyc) begin
          e = q.pop_front();
          n_chk++;
          n_fail++;
          $display("FAIL missing_resp: master %0d err=%0b expected at cycle %0d, did not arrive",
                   e.m, e.is_err, e.cyc);
        end
        if ((|bus.m_ack_o) || (|bus.m_err_o)) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_resp: ack=%b err=%b at cycle %0d, required none",
                     bus.m_ack_o, bus.m_err_o, cyc_cnt);
          end else begin
            e = q.pop_front();
            ea = e.is_err ? '0 : NM'(1) << e.m;
            ee = e.is_err ? NM'(1) << e.m : '0;
            chk("resp_ack", 64'(bus.m_ack_o), 64'(ea));
            chk("resp_err", 64'(bus.m_err_o), 64'(ee));
            chk("resp_cycle", 64'(cyc_cnt), 64'(e.cyc));
            if (e.chk_dat) chk("resp_dat", 64'(bus.m_dat_o), 64'(e.dat));
          end
        end
      end
    end
  endtask

  int p;
  exp_t left;

  initial begin
    bus.m_dat_i = '0; bus.m_adr_i = '0; bus.m_cti_i = '0; bus.m_sel_i = '0;
    bus.m_we_i = '0;  bus.m_cyc_i = '0; bus.m_stb_i = '0;
    bus.s_dat_i = '0; bus.s_ack_i = '0;
    fork
      monitor();
    join_none
    #2 rst_n = 1'b0;
    tick(); tick();
    at_neg();
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_ack", 64'(bus.m_ack_o), 64'h0);
    chk("rst_err", 64'(bus.m_err_o), 64'h0);
    chk("rst_scyc", 64'(bus.s_cyc_o), 64'h0);
    chk("rst_sstb", 64'(bus.s_stb_o), 64'h0);
    chk("rst_sadr", 64'(bus.s_adr_o), 64'h0);
    chk("rst_sdat", 64'(bus.s_dat_o), 64'h0);
    tick();
    rst_n = 1'b1;

    // 1: round robin among m0, m2, m5 with no dead cycle
    set_m(0, 1, 0, 32'h0, 0); set_m(2, 1, 0, 32'h0, 0); set_m(5, 1, 0, 32'h0, 0);
    at_neg(); chk("t1_latency", 64'(gnt), 64'h0);
    tick(); at_neg(); chk("t1_gnt_m0", 64'(gnt), 64'b000001);
    set_m(0, 0, 0, 32'h0, 0);
    tick(); at_neg(); chk("t1_gnt_m2", 64'(gnt), 64'b000100);
    set_m(2, 0, 0, 32'h0, 0);
    tick(); at_neg(); chk("t1_gnt_m5", 64'(gnt), 64'b100000);
    set_m(5, 0, 0, 32'h0, 0);
    tick(); at_neg(); chk("t1_idle", 64'(gnt), 64'h0);

    // 2: m3 reads slave 3, ack two cycles after strobe
    set_m(3, 1, 1, 32'h3000_0010, 0);
    tick(); at_neg(); p = cyc_cnt;
    chk("t2_gnt", 64'(gnt), 64'b001000);
    chk("t2_sstb", 64'(bus.s_stb_o), 64'b0001000);
    chk("t2_sadr", 64'(bus.s_adr_o), 64'h3000_0010);
    chk("t2_swe", 64'(bus.s_we_o), 64'h0);
    push(0, 3, 1, 32'hC0DE_0003, p + 2);
    tick(); tick();
    bus.s_ack_i[3] = 1'b1;
    bus.s_dat_i[3*32 +: 32] = 32'hC0DE_0003;
    tick();
    bus.s_ack_i[3] = 1'b0;
    bus.s_dat_i[3*32 +: 32] = 32'h0;
    set_m(3, 0, 0, 32'h0, 0);
    tick(); at_neg(); chk("t2_release", 64'(gnt), 64'h0);

    // 3: unmapped address gives a single err cycle, no slave strobe
    set_m(1, 1, 1, 32'hF000_0000, 0);
    tick(); at_neg(); p = cyc_cnt;
    chk("t3_gnt", 64'(gnt), 64'b000010);
    chk("t3_sstb", 64'(bus.s_stb_o), 64'h0);
    chk("t3_scyc", 64'(bus.s_cyc_o), 64'h0);
    push(1, 1, 0, 32'h0, p + 1);
    tick(); at_neg(); chk("t3_sstb_err", 64'(bus.s_stb_o), 64'h0);
    tick();
    set_m(1, 0, 0, 32'h0, 0);
    tick(); at_neg(); chk("t3_release", 64'(gnt), 64'h0);

    // 4: slave 2 never acks; err on the 9th strobe cycle with the strobe masked
    set_m(2, 1, 1, 32'h2000_0000, 1);
    tick(); at_neg(); p = cyc_cnt;
    chk("t4_gnt", 64'(gnt), 64'b000100);
    chk("t4_wdat", 64'(bus.s_dat_o), 64'h1000_0002);
    push(1, 2, 0, 32'h0, p + 8);
    for (int i = 0; i <= 8; i++) begin
      chk($sformatf("t4_sstb_%0d", i), 64'(bus.s_stb_o), (i < 8) ? 64'b0000100 : 64'h0);
      if (i < 8) begin
        tick(); at_neg();
      end
    end
    set_m(2, 0, 0, 32'h0, 0);
    tick(); at_neg(); chk("t4_release", 64'(gnt), 64'h0);

    // 5: ack on the terminal-count cycle wins; the next transfer gets a full timeout
    set_m(4, 1, 1, 32'h4000_0000, 0);
    tick(); at_neg(); p = cyc_cnt;
    chk("t5_gnt", 64'(gnt), 64'b010000);
    push(0, 4, 1, 32'hC0DE_0004, p + 7);
    push(1, 4, 0, 32'h0, p + 16);
    for (int i = 0; i < 7; i++) tick();
    bus.s_ack_i[4] = 1'b1;
    bus.s_dat_i[4*32 +: 32] = 32'hC0DE_0004;
    tick();
    bus.s_ack_i[4] = 1'b0;
    bus.s_dat_i[4*32 +: 32] = 32'h0;
    for (int i = 0; i < 8; i++) tick();
    at_neg();
    tick();
    set_m(4, 0, 0, 32'h0, 0);
    tick(); at_neg(); chk("t5_release", 64'(gnt), 64'h0);

    // 6: asynchronous reset mid-transfer, then a lone requester after release
    set_m(0, 1, 1, 32'h0000_0100, 0);
    tick(); at_neg(); chk("t6_gnt_m0", 64'(gnt), 64'b000001);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_gnt", 64'(gnt), 64'h0);
    chk("t6_async_scyc", 64'(bus.s_cyc_o), 64'h0);
    chk("t6_async_sstb", 64'(bus.s_stb_o), 64'h0);
    set_m(0, 0, 0, 32'h0, 0);
    tick(); tick();
    rst_n = 1'b1;
    set_m(1, 1, 0, 32'h0, 0);
    at_neg(); chk("t6_post_latency", 64'(gnt), 64'h0);
    tick(); at_neg(); chk("t6_gnt_m1", 64'(gnt), 64'b000010);
    set_m(1, 0, 0, 32'h0, 0);
    tick(); tick();

    while (q.size() > 0) begin
      left = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing_resp: master %0d err=%0b expected at cycle %0d, did not arrive",
               left.m, left.is_err, left.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
